// File: rtl/io_poll_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : io_poll_accumulator
// Purpose  : I/O-bus master that polls a status byte for FI and then sums
//            N_OPS bytes from the receive register (optionally saturating).
// Revision : 1.0  initial release
// ============================================================================
module io_poll_accumulator #(
    parameter int          N_OPS     = 2,
    parameter int          OUT_W     = 12,
    parameter logic [15:0] BASE_ADDR = 16'h0120,
    parameter logic [15:0] STS_OFF   = 16'h0000,
    parameter logic [15:0] RBR_OFF   = 16'h0001,
    parameter int          FI_BIT    = 0,
    parameter int          WAIT_CYC  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             accum,
    input  logic             clear,
    output logic [15:0]      addr,
    input  logic [7:0]       data,
    output logic             ior_,
    output logic             iow_,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             ovf,
    output logic             busy
);

    localparam int                 c_ACC_W     = 8 + $clog2(N_OPS);
    localparam int                 c_CNT_W     = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [15:0]        c_STS_ADDR  = BASE_ADDR + STS_OFF;
    localparam logic [15:0]        c_RBR_ADDR  = BASE_ADDR + RBR_OFF;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT  = c_CNT_W'(N_OPS - 1);
    localparam logic [2:0]         c_WAIT_LAST = 3'(WAIT_CYC);

    generate
        if (N_OPS < 1 || N_OPS > 16) begin : g_bad_n_ops
            $error("io_poll_accumulator: N_OPS must be within 1..16");
        end
        if (OUT_W < c_ACC_W) begin : g_bad_out_w
            $error("io_poll_accumulator: OUT_W must be at least 8+clog2(N_OPS)");
        end
        if (WAIT_CYC < 0 || WAIT_CYC > 7) begin : g_bad_wait
            $error("io_poll_accumulator: WAIT_CYC must be within 0..7");
        end
        if (FI_BIT < 0 || FI_BIT > 7) begin : g_bad_fi_bit
            $error("io_poll_accumulator: FI_BIT must be within 0..7");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_L = 3'd2,
        S_RD_S = 3'd3,
        S_CHK  = 3'd4,
        S_ADD  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t             r_state;
    logic               r_rd_rbr;     // read in flight targets the receive register
    logic [7:0]         r_op;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_wait;
    logic [15:0]        r_addr;
    logic               r_ior_n;
    logic [OUT_W-1:0]   r_out;
    logic               r_out_valid;
    logic               r_ovf;

    // One extra bit catches the carry that signals saturation.
    logic [OUT_W:0]     w_sum;
    assign w_sum = {1'b0, r_out} + (OUT_W+1)'(r_acc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd_rbr    <= 1'b0;
            r_op        <= 8'h00;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_wait      <= 3'd0;
            r_addr      <= 16'h0000;
            r_ior_n     <= 1'b1;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_out <= '0;
                        r_ovf <= 1'b0;
                    end else if (enable) begin
                        r_rd_rbr <= 1'b0;
                        r_state  <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    r_addr  <= r_rd_rbr ? c_RBR_ADDR : c_STS_ADDR;
                    r_wait  <= 3'd0;
                    r_state <= S_RD_L;
                end
                S_RD_L: begin
                    r_ior_n <= 1'b0;
                    if (r_wait == c_WAIT_LAST) begin
                        r_state <= S_RD_S;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_RD_S: begin
                    r_op    <= data;
                    r_ior_n <= 1'b1;
                    r_state <= r_rd_rbr ? S_ADD : S_CHK;
                end
                S_CHK: begin
                    if (r_op[FI_BIT]) begin
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_rd_rbr <= 1'b1;
                        r_state  <= S_RD_A;
                    end else if (enable) begin
                        r_rd_rbr <= 1'b0;
                        r_state  <= S_RD_A;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_acc <= r_acc + c_ACC_W'(r_op);
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_CNT) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RD_A;
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b1;
                    if (!accum) begin
                        r_out <= OUT_W'(r_acc);
                    end else if (w_sum[OUT_W]) begin
                        r_out <= '1;
                        r_ovf <= 1'b1;
                    end else begin
                        r_out <= w_sum[OUT_W-1:0];
                    end
                    if (enable) begin
                        r_rd_rbr <= 1'b0;
                        r_state  <= S_RD_A;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign addr      = r_addr;
    assign ior_      = r_ior_n;
    assign iow_      = 1'b1;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
